// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
// The accumulate states exist only when MULT_ACCUM_EN is defined.
package mult_pkg;

  localparam int MULT_W     = 32;
  localparam int MULT_ITERS = 32;

  localparam logic [1:0] ADD_SEL_RUN = 2'd0;
  localparam logic [1:0] ADD_SEL_NEG = 2'd1;
  localparam logic [1:0] ADD_SEL_ACC = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_NEG_LO,
    S_NEG_HI,
`ifdef MULT_ACCUM_EN
    S_ACC_LO,
    S_ACC_HI,
`endif
    S_DONE
  } mult_state_e;

  // Two's-complement magnitude; 0x8000_0000 maps onto itself, which is the
  // correct unsigned magnitude of -2^31.
  function automatic logic [MULT_W-1:0] mag(input logic [MULT_W-1:0] v,
                                           input logic             sgn);
    return (sgn && v[MULT_W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_add32.sv
// 32-bit adder with carry-in/carry-out; the single arithmetic resource
// shared by every phase of the multiplier sequence.
module add32_cin (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/mult_seq_ctrl.sv
// Radix-2 shift-add 32x32->64 multiplier sequencer with optional sign fix-up
// and HI/LO accumulate (accumulate built only when MULT_ACCUM_EN is defined).
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int W     = MULT_W,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef MULT_ACCUM_EN
  input  logic         acc_en,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  mult_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     mcand_q, mcand_d;
  logic [W-1:0]     p_hi_q, p_hi_d;
  logic [W-1:0]     lo_w_q, lo_w_d;
  logic             neg_q, neg_d;
  logic             c_q, c_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
`ifdef MULT_ACCUM_EN
  logic             acc_q, acc_d;
`endif

  logic [1:0]   add_sel;
  logic         lo_half;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  mult_state_e  after_neg;

  add32_cin u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Operand routing depends on state only; lo_half picks the word being fixed up.
  always_comb begin
    add_sel = ADD_SEL_ACC;
    lo_half = 1'b0;
    case (state_q)
      S_RUN:    add_sel = ADD_SEL_RUN;
      S_NEG_LO: begin add_sel = ADD_SEL_NEG; lo_half = 1'b1; end
      S_NEG_HI: add_sel = ADD_SEL_NEG;
`ifdef MULT_ACCUM_EN
      S_ACC_LO: lo_half = 1'b1;
`endif
      default:  add_sel = ADD_SEL_ACC;
    endcase
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (add_sel)
      ADD_SEL_RUN: begin
        add_a = p_hi_q;
        add_b = lo_w_q[0] ? mcand_q : '0;
      end
      ADD_SEL_NEG: begin
        add_a   = lo_half ? ~lo_w_q : ~p_hi_q;
        add_cin = lo_half ? 1'b1 : c_q;
      end
      ADD_SEL_ACC: begin
        add_a   = lo_half ? lo_w_q : p_hi_q;
        add_b   = lo_half ? lo_q : hi_q;
        add_cin = lo_half ? 1'b0 : c_q;
      end
      default: begin
        add_a = '0;
      end
    endcase
  end

`ifdef MULT_ACCUM_EN
  assign after_neg = acc_q ? S_ACC_LO : S_DONE;
`else
  assign after_neg = S_DONE;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    p_hi_d  = p_hi_q;
    lo_w_d  = lo_w_q;
    neg_d   = neg_q;
    c_d     = c_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULT_ACCUM_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          mcand_d = mag(a, is_signed);
          lo_w_d  = mag(b, is_signed);
          p_hi_d  = '0;
          neg_d   = is_signed & (a[W-1] ^ b[W-1]);
          cnt_d   = '0;
`ifdef MULT_ACCUM_EN
          acc_d   = acc_en;
`endif
        end
      end
      S_RUN: begin
        // Carry-out becomes the new MSB as the 64-bit partial product shifts right.
        p_hi_d = {add_cout, add_sum[W-1:1]};
        lo_w_d = {add_sum[0], lo_w_q[W-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MULT_ITERS - 1))
          state_d = neg_q ? S_NEG_LO : after_neg;
      end
      S_NEG_LO: begin
        lo_w_d  = add_sum;
        c_d     = add_cout;
        state_d = S_NEG_HI;
      end
      S_NEG_HI: begin
        p_hi_d  = add_sum;
        state_d = after_neg;
      end
`ifdef MULT_ACCUM_EN
      S_ACC_LO: begin
        lo_w_d  = add_sum;
        c_d     = add_cout;
        state_d = S_ACC_HI;
      end
      S_ACC_HI: begin
        p_hi_d  = add_sum;
        state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Result registers load on entry to DONE so hi/lo are valid alongside done.
    if (state_d == S_DONE) begin
      hi_d = p_hi_d;
      lo_d = lo_w_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      p_hi_q  <= '0;
      lo_w_q  <= '0;
      neg_q   <= 1'b0;
      c_q     <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULT_ACCUM_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      p_hi_q  <= p_hi_d;
      lo_w_q  <= lo_w_d;
      neg_q   <= neg_d;
      c_q     <= c_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULT_ACCUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed corner cases plus random
// operations against a 64-bit arithmetic reference model.
module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        acc_en;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks;
  int          n_errors;
  logic [63:0] model_prod;

  mult_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
`ifdef MULT_ACCUM_EN
    .acc_en    (acc_en),
`endif
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full operation. poke=1 also pulses start while busy and in the DONE cycle.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic sgn,
                        input logic acc, input bit poke);
    logic [63:0] sa, sb, expv;
    logic        acc_eff;
    int          exp_lat, lat;
    bit          seen;
`ifdef MULT_ACCUM_EN
    acc_eff = acc;
`else
    acc_eff = 1'b0;
`endif
    sa   = {{32{ta[31] & sgn}}, ta};
    sb   = {{32{tb_v[31] & sgn}}, tb_v};
    expv = sa * sb + (acc_eff ? model_prod : 64'd0);
    exp_lat = 33 + 2 * int'(sgn & (ta[31] ^ tb_v[31])) + 2 * int'(acc_eff);

    a = ta; b = tb_v; is_signed = sgn; acc_en = acc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom); acc_en = 1'($urandom);
    check_val("busy_after_start", {63'd0, busy}, 64'd1);

    seen = 0;
    lat  = 0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      if (poke && k == 10) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        seen = 1;
        lat  = k + 1;
      end else if (k % 8 == 0) begin
        check_val("hold_while_busy", {hi, lo}, model_prod);
      end
    end
    check_val("latency", 64'(lat), 64'(exp_lat));
    check_val("result", {hi, lo}, expv);
    check_val("busy_in_done", {63'd0, busy}, 64'd1);
    $display("op a=%08h b=%08h sgn=%0d acc=%0d poke=%0d -> hi=%08h lo=%08h lat=%0d", ta, tb_v,
             sgn, acc_eff, poke, hi, lo, lat);

    if (poke) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("idle_busy", {63'd0, busy}, 64'd0);
    check_val("idle_done", {63'd0, done}, 64'd0);
    check_val("idle_hold", {hi, lo}, expv);
    model_prod = expv;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    model_prod = 64'd0;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0; acc_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", {63'd0, busy}, 64'd0);
    check_val("reset_done", {63'd0, done}, 64'd0);
    check_val("reset_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    check_val("t1_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 1'b0);
    check_val("t2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    check_val("t3_const", {hi, lo}, 64'h4000_0000_0000_0000);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of an operation.
    a = 32'hDEAD_BEEF; b = 32'h0000_1234; is_signed = 1'b0; acc_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("midrst_busy", {63'd0, busy}, 64'd0);
    check_val("midrst_done", {63'd0, done}, 64'd0);
    check_val("midrst_hilo", {hi, lo}, 64'd0);
    $display("reset mid-operation -> busy=%0d done=%0d hi=%08h lo=%08h", busy, done, hi, lo);
    model_prod = 64'd0;
    run_op(32'h0001_0003, 32'h0000_0005, 1'b0, 1'b0, 1'b0);

`ifdef MULT_ACCUM_EN
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
    run_op(32'd1, 32'd1, 1'b0, 1'b1, 1'b0);
    check_val("t6_const", {hi, lo}, 64'h0000_0001_0000_0000);
`endif

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 0) ra = 32'h8000_0000;
      if (i % 7 == 3) rb = 32'd0;
      run_op(ra, rb, 1'($urandom), 1'($urandom), bit'(i % 5 == 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
